// File: rtl/spi_frame_builder.sv
// rtl/spi_frame_builder.sv - wraps sample groups into sync/header/payload/checksum frames for the SPI TX FIFO
module spi_frame_builder #(
  parameter int unsigned PAYLOAD_WORDS = 4,
  parameter logic [31:0] SYNC_WORD     = 32'hA5A5_5A5A
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        sample_ready,
  input  logic        fifo_afull,
  output logic        we,
  output logic [31:0] din,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] seq_num
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_WORDS - 1);
  localparam logic [15:0] HDR_LEN  = 16'(PAYLOAD_WORDS);

  state_t      state_q, state_d;
  logic [31:0] csum_q, csum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] din_q, din_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [15:0] seq_q, seq_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      csum_q  <= 32'd0;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      din_q   <= 32'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      seq_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      din_q   <= din_d;
      last_q  <= last_d;
      done_q  <= done_d;
      seq_q   <= seq_d;
    end
  end

  // last_q marks the cycle the checksum word is on the bus; done/seq follow it by one cycle
  always_comb begin
    state_d      = state_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    we_d         = 1'b0;
    din_d        = din_q;
    last_d       = 1'b0;
    done_d       = last_q;
    seq_d        = last_q ? seq_q + 16'd1 : seq_q;
    sample_ready = (state_q == S_PAYLOAD) && !fifo_afull;

    case (state_q)
      S_IDLE: begin
        csum_d = 32'd0;
        cnt_d  = 8'd0;
        if (enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!fifo_afull) begin
          we_d    = 1'b1;
          din_d   = SYNC_WORD;
          csum_d  = csum_q + SYNC_WORD;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!fifo_afull) begin
          we_d    = 1'b1;
          din_d   = {seq_q, HDR_LEN};
          csum_d  = csum_q + {seq_q, HDR_LEN};
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (sample_valid && sample_ready) begin
          we_d   = 1'b1;
          din_d  = sample_data;
          csum_d = csum_q + sample_data;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (!fifo_afull) begin
          we_d    = 1'b1;
          din_d   = csum_q;
          last_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign we         = we_q;
  assign din        = din_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);
  assign seq_num    = seq_q;

endmodule

// File: tb/tb_spi_frame_builder.sv
// tb/tb_spi_frame_builder.sv - directed self-checking bench for spi_frame_builder
module tb_spi_frame_builder;

  localparam int N = 4;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        sample_ready;
  logic        fifo_afull;
  logic        we;
  logic [31:0] din;
  logic        frame_done;
  logic        busy;
  logic [15:0] seq_num;

  spi_frame_builder #(.PAYLOAD_WORDS(N), .SYNC_WORD(SYNC)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .fifo_afull   (fifo_afull),
    .we           (we),
    .din          (din),
    .frame_done   (frame_done),
    .busy         (busy),
    .seq_num      (seq_num)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] src_q[$];
  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] seq_log[$];
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  bit          gap_mode = 1'b0;
  bit          we_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Source: presents the queue head; holds an unaccepted sample, optionally idles every other cycle
  initial begin
    bit hold;
    bit phase;
    bit acc;
    hold = 1'b0;
    phase = 1'b0;
    sample_valid = 1'b0;
    sample_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!(hold && src_q.size() > 0)) begin
        if (src_q.size() > 0 && (!gap_mode || phase)) begin
          sample_valid = 1'b1;
          sample_data  = src_q[0];
        end else begin
          sample_valid = 1'b0;
        end
      end
      phase = ~phase;
      #2;
      acc = sample_valid && sample_ready && nrst;
      if (acc) void'(src_q.pop_front());
      hold = sample_valid && !acc;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (nrst && frame_done) begin
        check("done_after_csum_write", 32'(we_prev), 32'd1);
        seq_log.push_back(seq_num);
        done_cnt++;
      end
      if (nrst && we) begin
        cap_q.push_back(din);
        wr_cnt++;
      end
      we_prev = we;
    end
  end

  function automatic void add_frame(input logic [15:0] seq, input logic [31:0] s0, s1, s2, s3);
    logic [31:0] w [N+2];
    logic [31:0] sum;
    w[0] = SYNC;
    w[1] = {seq, 16'(N)};
    w[2] = s0;
    w[3] = s1;
    w[4] = s2;
    w[5] = s3;
    sum = 32'd0;
    for (int i = 0; i < N + 2; i++) begin
      sum = sum + w[i];
      exp_q.push_back(w[i]);
    end
    exp_q.push_back(sum);
  endfunction

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
    seq_log.delete();
    wr_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int t;
    t = 0;
    while (wr_cnt < target && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check({tag, "_wr_reached"}, 32'(wr_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int t;
    t = 0;
    while (done_cnt < target && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check({tag, "_done_reached"}, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    nrst = 1'b0;
    enable = 1'b0;
    fifo_afull = 1'b0;
    tick(3);
    #2;
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq", 32'(seq_num), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Basic frame then a back-to-back second frame; enable drops once frame 2 has started
    clear_logs();
    for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
    add_frame(16'd0, 32'd1, 32'd2, 32'd3, 32'd4);
    add_frame(16'd1, 32'd5, 32'd6, 32'd7, 32'd8);
    enable = 1'b1;
    wait_wr(8, "b2b_sync2");
    enable = 1'b0;
    wait_done(2, "b2b");
    tick(2);
    compare_stream("b2b");
    check("b2b_csum1_const", cap_q.size() > 6 ? cap_q[6] : 32'hx, 32'hA5A5_5A68);
    check("b2b_csum2_const", cap_q.size() > 13 ? cap_q[13] : 32'hx, 32'hA5A6_5A78);
    check("b2b_seq_log_len", 32'(seq_log.size()), 32'd2);
    if (seq_log.size() >= 2) begin
      check("b2b_seq_after_f1", 32'(seq_log[0]), 32'd1);
      check("b2b_seq_after_f2", 32'(seq_log[1]), 32'd2);
    end

    // Back-pressure: 3 stall cycles in HDR, 2 in PAYLOAD
    clear_logs();
    for (int i = 1; i <= 4; i++) src_q.push_back(32'(i));
    add_frame(16'd2, 32'd1, 32'd2, 32'd3, 32'd4);
    enable = 1'b1;
    wait_wr(1, "bp_sync");
    enable = 1'b0;
    fifo_afull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) fifo_afull = 1'b0;
      #2;
      check($sformatf("bp_hdr_we_%0d", k), 32'(we), 32'd0);
      check($sformatf("bp_hdr_rdy_%0d", k), 32'(sample_ready), 32'd0);
    end
    wait_wr(3, "bp_w2");
    @(negedge clk);
    fifo_afull = 1'b1;
    #2;
    check("bp_pl_rdy_0", 32'(sample_ready), 32'd0);
    @(negedge clk);
    #2;
    check("bp_pl_rdy_1", 32'(sample_ready), 32'd0);
    check("bp_pl_we_1", 32'(we), 32'd0);
    @(negedge clk);
    fifo_afull = 1'b0;
    #2;
    check("bp_pl_we_2", 32'(we), 32'd0);
    wait_done(1, "bp");
    tick(2);
    compare_stream("bp");
    check("bp_src_drained", 32'(src_q.size()), 32'd0);

    // Source gaps and enable dropped mid-frame
    clear_logs();
    gap_mode = 1'b1;
    for (int i = 9; i <= 12; i++) src_q.push_back(32'(i));
    add_frame(16'd3, 32'd9, 32'd10, 32'd11, 32'd12);
    enable = 1'b1;
    wait_wr(3, "gap_w2");
    enable = 1'b0;
    wait_done(1, "gap");
    tick(6);
    #2;
    check("gap_idle_busy", 32'(busy), 32'd0);
    check("gap_idle_we", 32'(we), 32'd0);
    check("gap_no_extra_writes", 32'(wr_cnt), 32'(N + 3));
    compare_stream("gap");
    gap_mode = 1'b0;

    // Reset mid-frame, then a fresh frame restarting at seq 0
    clear_logs();
    for (int i = 13; i <= 16; i++) src_q.push_back(32'(i));
    enable = 1'b1;
    wait_wr(4, "rst_w3");
    enable = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_din", din, 32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_seq", 32'(seq_num), 32'd0);
    src_q.delete();
    clear_logs();
    tick(2);
    nrst = 1'b1;
    for (int i = 17; i <= 20; i++) src_q.push_back(32'(i));
    add_frame(16'd0, 32'd17, 32'd18, 32'd19, 32'd20);
    enable = 1'b1;
    wait_wr(3, "post_rst_w2");
    enable = 1'b0;
    wait_done(1, "post_rst");
    tick(2);
    compare_stream("post_rst");
    check("post_rst_hdr", cap_q.size() > 1 ? cap_q[1] : 32'hx, 32'h0000_0004);

    // Sequence wrap with all-ones payload
    clear_logs();
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    #2;
    check("wrap_preload", 32'(seq_num), 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) src_q.push_back(32'hFFFF_FFFF);
    for (int i = 21; i <= 24; i++) src_q.push_back(32'(i));
    add_frame(16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_frame(16'h0000, 32'd21, 32'd22, 32'd23, 32'd24);
    enable = 1'b1;
    wait_wr(8, "wrap_sync2");
    enable = 1'b0;
    wait_done(2, "wrap");
    tick(2);
    compare_stream("wrap");
    check("wrap_hdr1", cap_q.size() > 1 ? cap_q[1] : 32'hx, 32'hFFFF_0004);
    check("wrap_csum_const", cap_q.size() > 6 ? cap_q[6] : 32'hx, 32'hA5A4_5A5A);
    check("wrap_hdr2", cap_q.size() > 8 ? cap_q[8] : 32'hx, 32'h0000_0004);
    check("wrap_seq_final", 32'(seq_num), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
